adc_sample_capture: RTL and testbench

// - Front-end stage directly upstream of the IIR filter: drives a serial ADC, deserializes each conversion
//   and presents it on x as a 16-bit sign-magnitude sample (bit15 = sign, bits14:0 = magnitude).
// - Sample rate is set by an internal timer; x holds its value between conversions, so the filter sees a

---
 rtl/adc_sample_capture.sv | 160 ++++++++++++++++
 tb/tb_adc_sample_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_capture.sv
// Timer-triggered serial ADC front end: deserializes each conversion into a 16-bit sign-magnitude sample.
// Define CLIP_EN to clamp the shifted magnitude to CLIP_MAG[14:0].
module adc_sample_capture #(
  parameter int          ADC_BITS      = 12,
  parameter int          CLK_DIV       = 4,
  parameter int          CONV_CYCLES   = 2,
  parameter int          SAMPLE_PERIOD = 256,
  parameter int          OUT_SHIFT     = 3,
  parameter logic [15:0] CLIP_MAG      = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_sdo,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] x,
  output logic        x_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(2 * ADC_BITS);
  localparam logic [ADC_BITS:0] HALF = {1'b0, 1'b1, {(ADC_BITS-1){1'b0}}};

`ifdef CLIP_EN
  localparam logic CLAMP_ON = 1'b1;
`else
  localparam logic CLAMP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, UPDATE} state_t;

  state_t              state_r, state_s;
  logic [TW-1:0]       timer_r;
  logic                trig_r;
  logic [CW-1:0]       conv_cnt_r;
  logic [DW-1:0]       div_cnt_r;
  logic [PW-1:0]       ph_cnt_r;
  logic [ADC_BITS-1:0] shift_r;
  logic                cs_n_r, sclk_r, busy_r, overrun_r, x_valid_r;
  logic [15:0]         x_r;
  logic                conv_end_s, div_end_s, ph_end_s;

  // Offset-binary code to sign-magnitude; codes below mid-scale are strictly negative, so no -0.
  function automatic logic [15:0] to_sign_mag(input logic [ADC_BITS-1:0] code);
    logic [ADC_BITS:0] mag;
    logic [14:0]       mag_sh;
    logic              neg;
    neg = ~code[ADC_BITS-1];
    if (code[ADC_BITS-1]) begin
      mag = {2'b00, code[ADC_BITS-2:0]};
    end else begin
      mag = HALF - {1'b0, code};
    end
    mag_sh = {{(14-ADC_BITS){1'b0}}, mag} << OUT_SHIFT;
    if (CLAMP_ON && (mag_sh > CLIP_MAG[14:0])) begin
      mag_sh = CLIP_MAG[14:0];
    end
    return {neg, mag_sh};
  endfunction

  // Sample-rate timer; the wrap is registered as the conversion trigger.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      timer_r <= '0;
      trig_r  <= 1'b0;
    end else if (timer_r == TW'(SAMPLE_PERIOD - 1)) begin
      timer_r <= '0;
      trig_r  <= 1'b1;
    end else begin
      timer_r <= timer_r + TW'(1);
      trig_r  <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_s    = state_r;
    conv_end_s = (conv_cnt_r == CW'(CONV_CYCLES - 1));
    div_end_s  = (div_cnt_r == DW'(CLK_DIV - 1));
    ph_end_s   = (ph_cnt_r == PW'(2 * ADC_BITS - 1));
    case (state_r)
      IDLE:    if (trig_r) state_s = CONV; else state_s = IDLE;
      CONV:    if (conv_end_s) state_s = SHIFT; else state_s = CONV;
      SHIFT:   if (div_end_s && ph_end_s) state_s = UPDATE; else state_s = SHIFT;
      UPDATE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Serial interface timing, deserializer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_cnt_r <= '0;
      div_cnt_r  <= '0;
      ph_cnt_r   <= '0;
      shift_r    <= '0;
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      x_valid_r  <= 1'b0;
      x_r        <= 16'h0000;
    end else begin
      cs_n_r    <= ~((state_s == CONV) || (state_s == SHIFT));
      busy_r    <= (state_s != IDLE);
      overrun_r <= trig_r && (state_r != IDLE);
      x_valid_r <= 1'b0;
      case (state_r)
        CONV: begin
          conv_cnt_r <= conv_end_s ? '0 : conv_cnt_r + CW'(1);
        end
        SHIFT: begin
          if (div_end_s) begin
            div_cnt_r <= '0;
            sclk_r    <= ~sclk_r;
            ph_cnt_r  <= ph_end_s ? '0 : ph_cnt_r + PW'(1);
            // The edge that raises sclk captures the bit the ADC set up on the previous fall.
            if (!sclk_r) begin
              shift_r <= {shift_r[ADC_BITS-2:0], adc_sdo};
            end
          end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
          end
        end
        UPDATE: begin
          x_r       <= to_sign_mag(shift_r);
          x_valid_r <= 1'b1;
        end
        default: begin
          conv_cnt_r <= '0;
          div_cnt_r  <= '0;
          ph_cnt_r   <= '0;
          sclk_r     <= 1'b0;
        end
      endcase
    end
  end

  assign adc_cs_n = cs_n_r;
  assign adc_sclk = sclk_r;
  assign x        = x_r;
  assign x_valid  = x_valid_r;
  assign busy     = busy_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture with an ADC model and an expected-sample scoreboard.
// A second instance with SAMPLE_PERIOD=64 exercises overrun in the background.
module tb_adc_sample_capture;
  logic        clk = 1'b0;
  logic        rst, enable, adc_sdo, adc_cs_n, adc_sclk, x_valid, busy, overrun;
  logic [15:0] x;
  logic        rst64, enable64, sdo64, cs64, sclk64, xv64, busy64, ov64;
  logic [15:0] x64;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0] code_q[$];
  logic [15:0] stim_exp_q[$];
  logic [15:0] exp_q[$];

  localparam logic [11:0] CODE64 = 12'h001;

  adc_sample_capture dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_sdo(adc_sdo),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .x(x), .x_valid(x_valid),
    .busy(busy), .overrun(overrun)
  );

  adc_sample_capture #(.SAMPLE_PERIOD(64)) dut64 (
    .clk(clk), .rst(rst64), .enable(enable64), .adc_sdo(sdo64),
    .adc_cs_n(cs64), .adc_sclk(sclk64), .x(x64), .x_valid(xv64),
    .busy(busy64), .overrun(ov64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_x(input logic [11:0] code);
    int v;
    int m;
    logic [31:0] mv;
    v = int'(code) - 2048;
    m = (v < 0) ? -v : v;
    m = m * 8;
`ifdef CLIP_EN
    if (m > 32'h3000) m = 32'h3000;
`endif
    mv = m;
    return {(v < 0) ? 1'b1 : 1'b0, mv[14:0]};
  endfunction

  // ADC model and scoreboard for the main instance.
  logic        cs_prev = 1'b1, sclk_prev = 1'b0;
  logic [11:0] cur;
  int          bidx = 0, cs_falls = 0, cs_fall_cyc = 0, valids = 0;
  always @(negedge clk) begin
    if (cs_prev && !adc_cs_n) begin
      if (code_q.size() > 0) begin
        cur = code_q.pop_front();
        exp_q.push_back(stim_exp_q.pop_front());
      end else begin
        cur = 12'hC00;
        exp_q.push_back(16'h2000);
      end
      bidx = 11;
      adc_sdo = cur[bidx];
      cs_falls++;
      cs_fall_cyc = cyc;
    end else if (sclk_prev && !adc_sclk && bidx > 0) begin
      bidx--;
      adc_sdo = cur[bidx];
    end
    if (x_valid) begin
      valids++;
      if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else check("x_value", x, exp_q.pop_front());
      check("latency", cyc - cs_fall_cyc, 32'd99);
    end
    cs_prev = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  // ADC model and overrun monitor for the SAMPLE_PERIOD=64 instance.
  logic        cs64_prev = 1'b1, sclk64_prev = 1'b0;
  logic [11:0] cur64;
  int          bidx64 = 0, fall64 = 0, v64 = 0, o64 = 0, last_v64 = 0;
  always @(negedge clk) begin
    if (cs64_prev && !cs64) begin
      cur64 = CODE64;
      bidx64 = 11;
      sdo64 = cur64[bidx64];
      fall64 = cyc;
    end else if (sclk64_prev && !sclk64 && bidx64 > 0) begin
      bidx64--;
      sdo64 = cur64[bidx64];
    end
    if (xv64) begin
      v64++;
      check("x64_value", x64, model_x(CODE64));
      if (v64 > 1) check("x64_period", cyc - last_v64, 32'd128);
      last_v64 = cyc;
    end
    if (ov64) begin
      o64++;
      check("overrun_phase", cyc - fall64, 32'd64);
      check("overrun_busy", busy64, 1'b1);
    end
    cs64_prev = cs64;
    sclk64_prev = sclk64;
  end

  task automatic wait_valid(input string tag, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (x_valid !== 1'b1 && n < bound);
    if (x_valid !== 1'b1) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    logic [11:0] r;
    int rel, falls, vb, changed, n;
    rst = 1'b1; enable = 1'b1; adc_sdo = 1'b0;
    rst64 = 1'b1; enable64 = 1'b0; sdo64 = 1'b0;

    code_q.push_back(12'hC00); stim_exp_q.push_back(16'h2000);
    code_q.push_back(12'h400); stim_exp_q.push_back(16'hA000);
    code_q.push_back(12'h800); stim_exp_q.push_back(16'h0000);
`ifdef CLIP_EN
    code_q.push_back(12'hFFF); stim_exp_q.push_back(16'h3000);
    code_q.push_back(12'h000); stim_exp_q.push_back(16'hB000);
`else
    code_q.push_back(12'hFFF); stim_exp_q.push_back(16'h3FF8);
    code_q.push_back(12'h000); stim_exp_q.push_back(16'hC000);
`endif
    for (int i = 0; i < 2; i++) begin
      r = 12'($urandom_range(0, 4095));
      code_q.push_back(r); stim_exp_q.push_back(model_x(r));
    end

    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {x, x_valid, adc_cs_n, adc_sclk, busy, overrun},
            {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    rst = 1'b0; rst64 = 1'b0; enable64 = 1'b1;
    rel = cyc;

    n = 0;
    while (cs_falls == 0 && n < 300) begin @(negedge clk); n++; end
    check("first_cs_fall", cs_fall_cyc - rel, 32'd257);

    wait_valid("first_valid", 200);
    @(negedge clk);
    check("valid_one_cycle", x_valid, 1'b0);
    check("x_after_valid", x, 16'h2000);
    changed = 0; n = 0;
    while (x_valid !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
      if (x_valid !== 1'b1 && x !== 16'h2000) changed = 1;
    end
    check("x_held", changed, 32'd0);
    for (int i = 0; i < 5; i++) wait_valid("next_valid", 300);

    // enable drops mid-conversion: the sample finishes, no new conversions start.
    n = 0;
    while (adc_cs_n !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_valid("inflight_valid", 200);
    falls = cs_falls;
    repeat (600) @(negedge clk);
    check("no_cs_fall_disabled", cs_falls, falls);

    enable = 1'b1;
    rel = cyc;
    n = 0;
    while (cs_falls == falls && n < 300) begin @(negedge clk); n++; end
    check("reenable_cs_fall", cs_fall_cyc - rel, 32'd257);

    // Reset in the middle of SHIFT aborts the conversion.
    repeat (30) @(negedge clk);
    check("busy_mid_shift", {busy, adc_cs_n}, {1'b1, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {x, x_valid, adc_cs_n, adc_sclk, busy},
          {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    exp_q.delete();
    vb = valids;
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("no_valid_after_abort", valids, vb);
    check("x_stays_zero", x, 16'h0000);

    check("valids64_seen", (v64 >= 10) ? 32'd1 : 32'd0, 32'd1);
    check("overruns64", ((o64 == v64) || (o64 == v64 + 1)) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
